reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/lc3b_types.sv | 11 +
 rtl/reg_scoreboard_pend_counter.sv | 54 +++++
 rtl/reg_scoreboard.sv | 119 +++++++++++
 tb/tb_reg_scoreboard.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: register index type and scoreboard counter layout.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    // Pending counters 0..7 track R0..R7; index 8 tracks the condition codes.
    localparam int NUM_REGS = 8;
    localparam int CC_IDX   = 8;
    localparam int NUM_CNT  = 9;

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// pend_counter: saturating up/down pending-write counter with underflow pulse.
// A simultaneous increment and decrement cancel and leave the count unchanged.
module pend_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max,
    output logic             is_one,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: saturate at max, clamp at zero and flag the bad decrement.
    always_comb begin
        count_d   = count_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (dec && !inc) begin
            if (count_q == '0) begin
                underflow = 1'b1;
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign at_max  = (count_q == CNT_MAX);
    assign is_one  = (count_q == CNT_ONE);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: in-order issue interlock for an LC-3b pipeline. Tracks
// pending writes per register and for CC, and stalls decode on RAW hazards
// or when a pending counter would overflow.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN to let a source whose last
// pending write retires this cycle issue immediately (regfile writes through).
module reg_scoreboard
    import lc3b_types::*;
#(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic       id_uses_sr1,
    input  logic       id_uses_sr2,
    input  lc3b_reg    id_sr1,
    input  lc3b_reg    id_sr2,
    input  logic       id_writes_dest,
    input  lc3b_reg    id_dest,
    input  logic       id_uses_cc,
    input  logic       id_sets_cc,
    input  logic       ex_stall,
    input  logic       flush,
    input  logic       wb_load,
    input  lc3b_reg    wb_dest,
    input  logic       wb_sets_cc,
    output logic       issue,
    output logic       stall_id,
    output logic [7:0] busy,
    output logic       cc_busy,
    output logic       err_underflow
);

    logic [NUM_CNT-1:0] inc_vec;
    logic [NUM_CNT-1:0] dec_vec;
    logic [NUM_CNT-1:0] cnt_nonzero;
    logic [NUM_CNT-1:0] cnt_at_max;
    logic [NUM_CNT-1:0] cnt_is_one;
    logic [NUM_CNT-1:0] cnt_uflow;
    logic [NUM_CNT-1:0] src_pending;

    logic sr1_blk;
    logic sr2_blk;
    logic cc_blk;
    logic hazard;
    logic err_q;
    logic err_d;

    // A pending count blocks a reader; with bypass, the final retiring write does not.
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
`ifdef SCOREBOARD_WB_BYPASS_EN
            src_pending[i] = cnt_nonzero[i] & ~(cnt_is_one[i] & dec_vec[i]);
`else
            src_pending[i] = cnt_nonzero[i];
`endif
        end
    end

    // Hazard detection and issue/stall handshake; sr1==sr2 collapses naturally.
    always_comb begin
        sr1_blk  = id_uses_sr1 & src_pending[id_sr1];
        sr2_blk  = id_uses_sr2 & src_pending[id_sr2];
        cc_blk   = id_uses_cc & src_pending[CC_IDX];
        hazard   = sr1_blk | sr2_blk | cc_blk
                 | (id_writes_dest & cnt_at_max[id_dest])
                 | (id_sets_cc & cnt_at_max[CC_IDX]);
        issue    = id_valid & ~flush & ~ex_stall & ~hazard & ~reset;
        stall_id = id_valid & ~flush & (hazard | ex_stall);
    end

    // Per-counter increment on issue and decrement on writeback.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue & id_writes_dest & (id_dest == 3'(i));
            dec_vec[i] = wb_load & (wb_dest == 3'(i));
        end
        inc_vec[CC_IDX] = issue & id_sets_cc;
        dec_vec[CC_IDX] = wb_sets_cc;
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] count_unused;
            pend_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc_vec[gi]),
                .dec       (dec_vec[gi]),
                .count     (count_unused),
                .nonzero   (cnt_nonzero[gi]),
                .at_max    (cnt_at_max[gi]),
                .is_one    (cnt_is_one[gi]),
                .underflow (cnt_uflow[gi])
            );
        end
    endgenerate

    // Sticky underflow accumulation.
    always_comb begin
        err_d = err_q | (|cnt_uflow);
    end

    // Underflow flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign busy          = cnt_nonzero[NUM_REGS-1:0];
    assign cc_busy       = cnt_nonzero[CC_IDX];
    assign err_underflow = err_q & ~reset;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard (default build, CNT_W=2, no bypass).
// Stimulus pushes hand-computed expectations; a monitor pops and compares
// them at the negative edge of each driven cycle.
module tb_reg_scoreboard;

    logic       clk;
    logic       reset;
    logic       id_valid, id_uses_sr1, id_uses_sr2, id_writes_dest;
    logic [2:0] id_sr1, id_sr2, id_dest, wb_dest;
    logic       id_uses_cc, id_sets_cc, ex_stall, flush, wb_load, wb_sets_cc;
    logic       issue, stall_id, cc_busy, err_underflow;
    logic [7:0] busy;

    typedef struct {
        string      name;
        logic       issue;
        logic       stall;
        logic [7:0] busy;
        logic       cc_busy;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_writes_dest(id_writes_dest), .id_dest(id_dest),
        .id_uses_cc(id_uses_cc), .id_sets_cc(id_sets_cc),
        .ex_stall(ex_stall), .flush(flush),
        .wb_load(wb_load), .wb_dest(wb_dest), .wb_sets_cc(wb_sets_cc),
        .issue(issue), .stall_id(stall_id), .busy(busy),
        .cc_busy(cc_busy), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, req);
        end
    endtask

    // Monitor: compare the DUT against the expectation queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "issue", {7'd0, issue}, {7'd0, e.issue});
            chk(e.name, "stall_id", {7'd0, stall_id}, {7'd0, e.stall});
            chk(e.name, "busy", busy, e.busy);
            chk(e.name, "cc_busy", {7'd0, cc_busy}, {7'd0, e.cc_busy});
            chk(e.name, "err", {7'd0, err_underflow}, {7'd0, e.err});
            $display("[%0t] %-6s issue=%b stall=%b busy=%h cc=%b err=%b", $time, e.name,
                     issue, stall_id, busy, cc_busy, err_underflow);
        end
    end

    // Start a cycle: just after the rising edge, return all inputs to idle.
    task automatic cyc();
        @(posedge clk);
        #1;
        reset = 1'b0; id_valid = 1'b0; id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0;
        id_sr1 = 3'd0; id_sr2 = 3'd0; id_writes_dest = 1'b0; id_dest = 3'd0;
        id_uses_cc = 1'b0; id_sets_cc = 1'b0; ex_stall = 1'b0; flush = 1'b0;
        wb_load = 1'b0; wb_dest = 3'd0; wb_sets_cc = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic i, input logic s,
                              input logic [7:0] b, input logic c, input logic e);
        exp_t x;
        x.name = name; x.issue = i; x.stall = s; x.busy = b; x.cc_busy = c; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wr(input logic [2:0] d);
        id_valid = 1'b1; id_writes_dest = 1'b1; id_dest = d;
    endtask

    task automatic add_r2_r1();
        id_valid = 1'b1; id_uses_sr1 = 1'b1; id_sr1 = 3'd1;
        id_uses_sr2 = 1'b1; id_sr2 = 3'd1; id_writes_dest = 1'b1; id_dest = 3'd2;
    endtask

    task automatic wb(input logic [2:0] d);
        wb_load = 1'b1; wb_dest = d;
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 1'b0; id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0; id_sr1 = 3'd0;
        id_sr2 = 3'd0; id_writes_dest = 1'b0; id_dest = 3'd0; id_uses_cc = 1'b0;
        id_sets_cc = 1'b0; ex_stall = 1'b0; flush = 1'b0; wb_load = 1'b0;
        wb_dest = 3'd0; wb_sets_cc = 1'b0;

        // Reset: issue suppressed even with a valid writer present.
        cyc(); reset = 1'b1; wr(3'd1);            expect_out("rst0", 0, 0, 8'h00, 0, 0);
        cyc();                                     expect_out("rst1", 0, 0, 8'h00, 0, 0);

        // Case 1: RAW on R1, released the cycle after writeback.
        cyc(); wr(3'd1);                           expect_out("c1a", 1, 0, 8'h00, 0, 0);
        cyc(); add_r2_r1();                        expect_out("c1b", 0, 1, 8'h02, 0, 0);
        cyc(); add_r2_r1();                        expect_out("c1c", 0, 1, 8'h02, 0, 0);
        cyc(); add_r2_r1(); wb(3'd1);              expect_out("c1d", 0, 1, 8'h02, 0, 0);
        cyc(); add_r2_r1();                        expect_out("c1e", 1, 0, 8'h00, 0, 0);
        cyc();                                     expect_out("c1f", 0, 0, 8'h04, 0, 0);
        cyc(); wb(3'd2);                           expect_out("c1g", 0, 0, 8'h04, 0, 0);
        cyc();                                     expect_out("c1h", 0, 0, 8'h00, 0, 0);

        // Case 2: R3 saturates at three pending writes.
        cyc(); wr(3'd3);                           expect_out("c2a", 1, 0, 8'h00, 0, 0);
        cyc(); wr(3'd3);                           expect_out("c2b", 1, 0, 8'h08, 0, 0);
        cyc(); wr(3'd3);                           expect_out("c2c", 1, 0, 8'h08, 0, 0);
        cyc(); wr(3'd3);                           expect_out("c2d", 0, 1, 8'h08, 0, 0);
        cyc(); wr(3'd3); wb(3'd3);                 expect_out("c2e", 0, 1, 8'h08, 0, 0);
        cyc(); wr(3'd3);                           expect_out("c2f", 1, 0, 8'h08, 0, 0);
        cyc(); wb(3'd3);                           expect_out("c2g", 0, 0, 8'h08, 0, 0);
        cyc(); wb(3'd3);                           expect_out("c2h", 0, 0, 8'h08, 0, 0);
        cyc(); wb(3'd3);                           expect_out("c2i", 0, 0, 8'h08, 0, 0);
        cyc();                                     expect_out("c2j", 0, 0, 8'h00, 0, 0);

        // Case 3: simultaneous issue and writeback on R4 leaves count at 1.
        cyc(); wr(3'd4);                           expect_out("c3a", 1, 0, 8'h00, 0, 0);
        cyc(); wr(3'd4); wb(3'd4);                 expect_out("c3b", 1, 0, 8'h10, 0, 0);
        cyc();                                     expect_out("c3c", 0, 0, 8'h10, 0, 0);
        cyc(); wb(3'd4);                           expect_out("c3d", 0, 0, 8'h10, 0, 0);
        cyc();                                     expect_out("c3e", 0, 0, 8'h00, 0, 0);

        // Downstream stall blocks issue and leaves counters alone.
        cyc(); wr(3'd6); ex_stall = 1'b1;          expect_out("exs", 0, 1, 8'h00, 0, 0);
        cyc();                                     expect_out("exs1", 0, 0, 8'h00, 0, 0);

        // Case 5: CC dependency, flush, and release after CC writeback.
        cyc(); id_valid = 1'b1; id_sets_cc = 1'b1; expect_out("c5a", 1, 0, 8'h00, 0, 0);
        cyc(); id_valid = 1'b1; id_uses_cc = 1'b1; flush = 1'b1;
                                                   expect_out("c5b", 0, 0, 8'h00, 1, 0);
        cyc(); id_valid = 1'b1; id_uses_cc = 1'b1; expect_out("c5c", 0, 1, 8'h00, 1, 0);
        cyc(); id_valid = 1'b1; id_uses_cc = 1'b1; wb_sets_cc = 1'b1;
                                                   expect_out("c5d", 0, 1, 8'h00, 1, 0);
        cyc(); id_valid = 1'b1; id_uses_cc = 1'b1; expect_out("c5e", 1, 0, 8'h00, 0, 0);

        // Case 4: underflow is sticky until reset.
        cyc(); wb(3'd5);                           expect_out("c4a", 0, 0, 8'h00, 0, 0);
        cyc();                                     expect_out("c4b", 0, 0, 8'h00, 0, 1);
        cyc();                                     expect_out("c4c", 0, 0, 8'h00, 0, 1);

        // Mid-operation reset discards pending counts; later writeback underflows.
        cyc(); wr(3'd0);                           expect_out("mr0", 1, 0, 8'h00, 0, 1);
        cyc();                                     expect_out("mr1", 0, 0, 8'h01, 0, 1);
        cyc(); reset = 1'b1; wr(3'd2);             expect_out("mr2", 0, 0, 8'h01, 0, 0);
        cyc();                                     expect_out("mr3", 0, 0, 8'h00, 0, 0);
        cyc(); wb(3'd0);                           expect_out("mr4", 0, 0, 8'h00, 0, 0);
        cyc();                                     expect_out("mr5", 0, 0, 8'h00, 0, 1);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
